// File: rtl/data_cal_packer_if.sv
// Stream bundle between the nibble-sum calculator, the packer and its consumer.
// Input side: in_data/in_valid with no back-pressure, so a sample is taken on every
// edge where in_valid=1. Output side: valid/ready. The head word transfers on an edge
// where out_valid=1 and out_ready=1. out_valid never depends on out_ready, and out_*
// stay stable while out_valid=1 until the transfer happens.
interface data_cal_packer_if #(
    parameter int IN_W   = 5,
    parameter int PACK_N = 3
);
    logic [IN_W-1:0]        in_data;
    logic                   in_valid;
    logic [PACK_N*IN_W-1:0] out_data;
    logic [2:0]             out_cnt;
    logic [IN_W+1:0]        out_sum;
    logic                   out_valid;
    logic                   out_ready;

    // Environment side: produces samples and consumes packed words.
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_cnt, out_sum, out_valid
    );

    // Packer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_cnt, out_sum, out_valid
    );
endinterface

// File: rtl/data_cal_packer.sv
// Packs PACK_N consecutive calculator results into one word, tagged with its sample
// count and sum, and queues the word in a DEPTH-entry show-ahead FIFO.
module data_cal_packer #(
    parameter int IN_W   = 5,
    parameter int PACK_N = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    data_cal_packer_if.slave         bus,
    input  logic                     flush_i,
    input  logic                     ovf_clr_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = PACK_N * IN_W;
    localparam int SW = IN_W + 2;
    localparam int EW = DW + 3 + SW;

    // Packer state
    logic [DW-1:0] word_q, word_d, acc_word;
    logic [SW-1:0] sum_q, sum_d, acc_sum;
    logic [2:0]    n_q, n_d, acc_n;
    logic          push;

    // FIFO state; pointers carry one extra bit so full and empty are distinct
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level;
    logic          empty, full, pop, wr_en, drop;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] head;

    // Merge this cycle's sample into the packer and decide whether the word goes out
    always_comb begin
        acc_word = word_q;
        acc_sum  = sum_q;
        acc_n    = n_q;
        if (bus.in_valid) begin
            for (int k = 0; k < PACK_N; k++) begin
                if (n_q == 3'(k)) begin
                    acc_word[k*IN_W +: IN_W] = bus.in_data;
                end
            end
            acc_sum = sum_q + SW'(bus.in_data);
            acc_n   = n_q + 3'd1;
        end
        push = (acc_n == 3'(PACK_N)) || (flush_i && (acc_n != 3'd0));
        // A pushed word always empties the packer, even when the FIFO drops it
        word_d = push ? '0 : acc_word;
        sum_d  = push ? '0 : acc_sum;
        n_d    = push ? 3'd0 : acc_n;
    end

    // FIFO bookkeeping; a pop frees a slot for a push on the same edge
    always_comb begin
        level = wr_q - rd_q;
        empty = (level == '0);
        full  = (level == (AW+1)'(DEPTH));
        pop   = !empty && bus.out_ready;
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
        wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d  = pop   ? rd_q + 1'b1 : rd_q;
        // A drop sets the flag even if a clear is requested on the same edge
        ovf_d = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    // Packer, pointers and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            sum_q  <= '0;
            n_q    <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            sum_q  <= sum_d;
            n_q    <= n_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= {acc_word, acc_n, acc_sum};
        end
    end

    // Show-ahead head entry, forced to zero while empty
    always_comb begin
        head          = empty ? '0 : mem_q[rd_q[AW-1:0]];
        bus.out_data  = head[EW-1 -: DW];
        bus.out_cnt   = head[SW +: 3];
        bus.out_sum   = head[SW-1:0];
        bus.out_valid = !empty;
        level_o       = level;
        overflow_o    = ovf_q;
    end
endmodule
